// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: big-endian data memory with power-on clear, branch resolve, MEM/WB register
module mem_access_stage #(
  parameter int DEPTH    = 256,
  parameter int BR_NE_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] wr_data,
  input  logic        zero,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        ready,
  output logic        pc_src,
  output logic        out_valid,
  output logic [31:0] read_data,
  output logic [31:0] alu_out,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic NE_EN = (BR_NE_EN != 0);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          is_mem;
  logic          misaligned;
  logic          bad_size;
  logic          out_of_range;
  logic          rw_conflict;
  logic          suppress;
  logic          do_store;
  logic          do_load;
  logic [AW-1:0] widx;
  logic [1:0]    boff;
  logic [31:0]   cur_word;
  logic [31:0]   st_mask;
  logic [31:0]   st_data;
  logic [31:0]   byte_shift;
  logic [31:0]   half_shift;
  logic [31:0]   ld_word;

  assign ready  = (state == RUN);
  assign accept = in_valid & ready;
  assign widx   = alu_result[AW+1:2];
  assign boff   = alu_result[1:0];

  assign pc_src = accept & branch & (zero ^ (branch_ne & NE_EN));

  assign is_mem       = mem_read | mem_write;
  assign misaligned   = ((size == 2'b01) & boff[0]) | ((size == 2'b10) & (boff != 2'b00));
  assign bad_size     = (size == 2'b11);
  assign out_of_range = |alu_result[31:AW+2];
  assign rw_conflict  = mem_read & mem_write;
  assign suppress     = is_mem & (misaligned | bad_size | out_of_range | rw_conflict);

  assign do_store = accept & mem_write & ~suppress;
  assign do_load  = mem_read & ~suppress;

  // Asynchronous read, so a load right after a store sees the updated word.
  assign cur_word = mem[widx];

  // Store lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    st_mask = 32'h0;
    st_data = 32'h0;
    case (size)
      2'b00: begin
        st_mask = 32'hFF00_0000 >> {boff, 3'b000};
        st_data = {4{wr_data[7:0]}};
      end
      2'b01: begin
        st_mask = boff[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        st_data = {2{wr_data[15:0]}};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_data = wr_data;
      end
    endcase
  end

  // Left-justify the addressed byte/half so it sits in the top bits.
  assign byte_shift = cur_word << {boff, 3'b000};
  assign half_shift = cur_word << {boff[1], 4'b0000};

  always_comb begin
    ld_word = cur_word;
    case (size)
      2'b00:   ld_word = {{24{sign_ext & byte_shift[31]}}, byte_shift[31:24]};
      2'b01:   ld_word = {{16{sign_ext & half_shift[31]}}, half_shift[31:16]};
      default: ld_word = cur_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= 32'h0;
      end else if (do_store) begin
        mem[widx] <= (cur_word & ~st_mask) | (st_data & st_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      out_valid <= 1'b0;
      fault     <= 1'b0;
      read_data <= 32'h0;
      alu_out   <= 32'h0;
    end else begin
      out_valid <= accept;
      fault     <= accept & suppress;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) begin
          state <= RUN;
        end
      end
      if (accept) begin
        alu_out   <= alu_result;
        read_data <= do_load ? ld_word : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage against a byte-array reference model
module tb_mem_access_stage;

  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] wr_data;
  logic        zero;
  logic        branch;
  logic        branch_ne;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        sign_ext;

  logic        ready, pc_src, out_valid, fault;
  logic [31:0] read_data, alu_out;
  logic        ready2, pc_src2, out_valid2, fault2;
  logic [31:0] read_data2, alu_out2;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [NBYTES];
  logic        m_ready;
  logic [31:0] m_rd;
  logic [31:0] m_alu;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(DEPTH), .BR_NE_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result), .wr_data(wr_data),
    .zero(zero), .branch(branch), .branch_ne(branch_ne), .mem_write(mem_write), .mem_read(mem_read),
    .size(size), .sign_ext(sign_ext), .ready(ready), .pc_src(pc_src), .out_valid(out_valid),
    .read_data(read_data), .alu_out(alu_out), .fault(fault)
  );

  mem_access_stage #(.DEPTH(DEPTH), .BR_NE_EN(0)) dut_ne_off (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result), .wr_data(wr_data),
    .zero(zero), .branch(branch), .branch_ne(branch_ne), .mem_write(mem_write), .mem_read(mem_read),
    .size(size), .sign_ext(sign_ext), .ready(ready2), .pc_src(pc_src2), .out_valid(out_valid2),
    .read_data(read_data2), .alu_out(alu_out2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_fault(input logic [31:0] a, input logic [1:0] sz, input logic rd, input logic wr);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    if (a >= NBYTES) return 1'b1;
    if ((a % nbytes_of(sz)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic se);
    int n;
    logic [31:0] v;
    n = nbytes_of(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[a + i]);
    if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = nbytes_of(sz);
    for (int i = 0; i < n; i++) mb[a + i] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic set_idle();
    in_valid = 0; alu_result = 0; wr_data = 0; zero = 0; branch = 0; branch_ne = 0;
    mem_write = 0; mem_read = 0; size = 0; sign_ext = 0;
  endtask

  // One cycle: present inputs, check pc_src, clock, check the MEM/WB register.
  task automatic do_op(input logic v, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input logic rd, input logic wr, input logic se,
                       input logic br, input logic bne, input logic z);
    logic acc, f;
    in_valid = v; alu_result = a; wr_data = wd; size = sz; mem_read = rd; mem_write = wr;
    sign_ext = se; branch = br; branch_ne = bne; zero = z;
    #1;
    acc = v & m_ready;
    chk("pc_src", {31'b0, pc_src}, {31'b0, acc & br & (z ^ bne)});
    chk("pc_src_ne_off", {31'b0, pc_src2}, {31'b0, acc & br & z});
    f = ref_fault(a, sz, rd, wr);
    if (acc) begin
      m_alu = a;
      m_rd  = (!f && rd) ? ref_load(a, sz, se) : 32'h0;
      if (!f && wr) ref_store(a, sz, wd);
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, acc});
    chk("fault", {31'b0, fault}, {31'b0, acc & f});
    chk("read_data", read_data, m_rd);
    chk("alu_out", alu_out, m_alu);
    chk("fault_ne_off", {31'b0, fault2}, {31'b0, acc & f});
    chk("read_data_ne_off", read_data2, m_rd);
    chk("alu_out_ne_off", alu_out2, m_alu);
    chk("out_valid_ne_off", {31'b0, out_valid2}, {31'b0, acc});
  endtask

  // Reset with a store presented in the same cycle, then watch the clear sweep while ops are offered.
  task automatic do_reset();
    rst = 1; in_valid = 1; mem_write = 1; size = 2'b10; alu_result = 0; wr_data = 32'hDEAD_BEEF;
    branch = 1; zero = 1; branch_ne = 0;
    @(posedge clk);
    #1;
    m_ready = 0; m_rd = 0; m_alu = 0;
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    rst = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k < DEPTH + 1) chk("clear_pc_src", {31'b0, pc_src}, 32'd0);
      @(posedge clk);
      #1;
      chk("clear_ready", {31'b0, ready}, {31'b0, k == DEPTH});
      chk("clear_ready_ne_off", {31'b0, ready2}, {31'b0, k == DEPTH});
      chk("clear_out_valid", {31'b0, out_valid}, 32'd0);
    end
    set_idle();
    m_ready = 1;
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1, 32'(i * 4), 0, 2'b10, 1, 0, 0, 0, 0, 0);
      chk("clear_word_zero", read_data, 32'd0);
      chk("clear_word_fault", {31'b0, fault}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        rd, wr;
    int          r;

    set_idle();
    rst = 1;
    m_ready = 0; m_rd = 0; m_alu = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_all_zero();

    // Byte lane merge
    do_op(1, 32'h0, 32'h1122_3344, 2'b10, 0, 1, 0, 0, 0, 0);
    do_op(1, 32'h2, 32'h0000_00AB, 2'b00, 0, 1, 0, 0, 0, 0);
    do_op(1, 32'h0, 0, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("byte_lane_word", read_data, 32'h1122_AB44);

    // Sign and zero extension
    do_op(1, 32'h4, 32'h80FF_7F01, 2'b10, 0, 1, 0, 0, 0, 0);
    do_op(1, 32'h4, 0, 2'b01, 1, 0, 1, 0, 0, 0);
    chk("signed_half", read_data, 32'hFFFF_80FF);
    do_op(1, 32'h6, 0, 2'b00, 1, 0, 0, 0, 0, 0);
    chk("unsigned_byte", read_data, 32'h0000_007F);
    do_op(1, 32'h7, 0, 2'b00, 1, 0, 1, 0, 0, 0);
    chk("signed_byte", read_data, 32'h0000_0001);

    // Branch combinations (pc_src checked inside do_op for both instances)
    do_op(1, 32'h100, 0, 2'b00, 0, 0, 0, 1, 0, 1);
    do_op(1, 32'h104, 0, 2'b00, 0, 0, 0, 1, 1, 1);
    do_op(1, 32'h108, 0, 2'b00, 0, 0, 0, 1, 1, 0);
    do_op(1, 32'h8, 32'h5555_AAAA, 2'b10, 0, 1, 0, 1, 1, 0);

    // Suppressed operations leave memory untouched
    do_op(1, 32'h2, 32'hCAFE_F00D, 2'b10, 0, 1, 0, 0, 0, 0);
    chk("fault_misaligned", {31'b0, fault}, 32'd1);
    do_op(1, 32'h0, 32'hCAFE_F00D, 2'b10, 1, 1, 0, 0, 0, 0);
    chk("fault_rw_both", {31'b0, fault}, 32'd1);
    do_op(1, 32'(NBYTES), 0, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("fault_range", {31'b0, fault}, 32'd1);
    chk("fault_range_rd", read_data, 32'd0);
    do_op(1, 32'h0, 0, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("fault_mem_unchanged", read_data, 32'h1122_AB44);

    // Back-to-back
    do_op(1, 32'h0, 32'd70, 2'b10, 0, 1, 0, 0, 0, 0);
    do_op(1, 32'h4, 32'd80, 2'b10, 0, 1, 0, 0, 0, 0);
    do_op(1, 32'h0, 0, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("b2b_load", read_data, 32'd70);
    do_op(0, 32'h44, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 4) || (r == 9);
      wr = (r >= 4 && r < 8) || (r == 9);
      sz = (rd || wr) ? 2'($urandom_range(0, 3)) : 2'b00;
      a  = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 2) != 0) a = a & ~32'(nbytes_of(sz) - 1);
      if ($urandom_range(0, 14) == 0) a = a | (32'h1 << $urandom_range(6, 31));
      wd = $urandom;
      do_op($urandom_range(0, 9) != 0, a, wd, sz, rd, wr, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Restart mid-CLEAR, then mid-RUN reset with a store in the reset cycle
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    check_all_zero();
    do_op(1, 32'hC, 32'h1234_5678, 2'b10, 0, 1, 0, 0, 0, 0);
    do_reset();
    check_all_zero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DEPTH, default 256: data memory size in 32-bit words; power of two, 4..4096.
REQ-002 Parameter BR_NE_EN, default 1: 1 enables the branch-on-not-equal mode; 0 forces branch_ne to be treated as 0.
REQ-003 One clock, clk; reset rst is synchronous and active-high.
REQ-004 Ports, in order: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  the EX/MEM operation below is present this cycle.
- alu_result  in  32  byte address for loads and stores; pass-through for non-memory operations.
- wr_data  in  32  store data, right-aligned for byte and half stores.
- zero  in  1  ALU zero flag.
- branch  in  1  the operation is a branch.
- branch_ne  in  1  1 = branch on not-equal; 0 = branch on equal.
- mem_write  in  1  store.
- mem_read  in  1  load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  sign-extend byte and half loads.
- ready  out  1  block accepts operations.
- pc_src  out  1  branch taken; combinational.
- out_valid  out  1  MEM/WB register holds a result.
- read_data  out  32  registered load result.
- alu_out  out  32  registered copy of alu_result.
- fault  out  1  registered; the operation was suppressed.

Function
REQ-005 Memory organisation: DEPTH words, big-endian; byte offset 0 is bits 31:24; word index is alu_result[log2(DEPTH)+1:2].
REQ-006 pc_src is (in_valid & ready & branch & (zero XOR (branch_ne & BR_NE_EN))); it is combinational with no memory access.
REQ-007 The block has a two-state FSM, CLEAR and RUN; rst forces CLEAR with the clear index at 0.
REQ-008 In CLEAR, the block writes zero to one word per cycle, index 0..DEPTH-1, and moves to RUN after writing DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-009 ready is 1 only in RUN; while ready=0, all inputs are ignored, pc_src=0 and out_valid=0.
REQ-010 An operation is accepted when in_valid & ready; each accepted operation produces exactly one out_valid pulse one cycle later, with no stalls, so throughput is one operation per cycle.
REQ-011 A store updates only the addressed byte lanes at the accepting clock edge.
- byte: wr_data[7:0] to lane offset addr[1:0].
- half: wr_data[15:0] to lanes addr[1]*2 and addr[1]*2+1.
- word: all four lanes.
REQ-012 A load is captured at the accepting edge into read_data, with a latency of 1 cycle.
- byte and half loads are zero-extended, or sign-extended when sign_ext=1.
- word loads are returned unmodified.
REQ-013 A load in the cycle after a store to the same word returns the post-store contents.
REQ-014 A non-load accepted operation drives read_data to 0.
REQ-015 The operation is suppressed (no memory change, read_data=0, fault=1 with that out_valid) on any of these conditions:
- half with addr[0]=1, or word with addr[1:0]≠0;
- size=11 together with mem_read or mem_write;
- alu_result[31:log2(DEPTH)+2] ≠ 0 together with mem_read or mem_write;
- mem_read and mem_write both 1.
REQ-016 alu_out receives alu_result on every accepted operation, including suppressed ones.
REQ-017 When no operation is accepted, out_valid=0, fault=0, and read_data and alu_out hold their values.
REQ-018 An accepted branch still produces out_valid and may also load or store; branch and memory access are independent.

Reset
REQ-019 At a clk edge with rst=1, the block sets: ready=0, out_valid=0, fault=0, read_data=0, alu_out=0, FSM=CLEAR, clear index=0.
REQ-020 rst asserted mid-CLEAR or mid-RUN restarts CLEAR from index 0; an operation presented in the same cycle as rst is discarded.
REQ-021 After rst deasserts, ready rises exactly DEPTH cycles later, and every word then reads 0.

Verification
REQ-022 Reset clear: DEPTH=16, pulse rst for one cycle -> ready=0 for 16 cycles, then 1; a word load at every address returns 0 with fault=0.
REQ-023 Byte lanes: store word 0x11223344 at 0x0, then store byte 0xAB at 0x2, then load word at 0x0 -> read_data=0x1122AB44 one cycle after the load is accepted.
REQ-024 Sign extension: store word 0x80FF7F01 at 0x4; a signed half load at 0x4 gives 0xFFFF80FF; an unsigned byte load at 0x6 gives 0x0000007F; a signed byte load at 0x7 gives 0x00000001.
REQ-025 Branch: zero=1, branch=1, branch_ne=0 gives pc_src=1; with branch_ne=1 gives pc_src=0; with zero=0 and branch_ne=1 gives pc_src=1; with BR_NE_EN=0, zero=0 and branch_ne=1 gives pc_src=0.
REQ-026 Faults: word store at 0x2; mem_read and mem_write together at 0x0; a word load at DEPTH*4 -> each gives out_valid=1, fault=1, read_data=0, and memory unchanged.
REQ-027 Back-to-back: 70 stored at 0x0 in cycle n, 80 stored at 0x4 in cycle n+1, load at 0x0 in cycle n+2 -> out_valid in each of cycles n+1..n+3, and read_data=70 in cycle n+3.
